uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised, oversampling UART receiver; next generation of the team's fixed 8N1 receiver.
- Adds configurable frame format (data bits, parity, stop bits) and an input synchroniser.
- Adds mid-bit sampling with start-bit validation, error flags, and a valid/ready output register with overrun detection.
- Sits between the raw RX pin and byte-stream consumers (command parser, FIFO) in the uart_clk domain.

Parameters:
- CLKS_PER_BIT, 16: uart_clk cycles per bit. Must be >= 4. HALF = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8: payload bits per frame, 5..9. Received LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 2: flops in the uart_in synchroniser, >= 2.

Ports:
- uart_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- uart_in  in  1  asynchronous serial line, idle high.
- data  out  DATA_BITS  received word; stable while data_valid=1.
- data_valid  out  1  word held in output register.
- data_ready  in  1  consumer accepts; transfer occurs when data_valid && data_ready.
- parity_err  out  1  parity mismatch for the held word; 0 when PARITY=0.
- frame_err  out  1  a stop bit was sampled low for the held word.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - data=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, armed=0, synchroniser flops set to 1.
  - A reset asserted mid-frame abandons the frame; nothing is delivered.
- Sampling: "rx" is the last synchroniser stage. All decisions use rx only. Bit counter width is $clog2(DATA_BITS).
- IDLE:
  - armed is set when rx=1.
  - When armed && rx=0, go to START, load counter HALF-1, busy=1.
- START:
  - The counter decrements each cycle. At 0, sample rx.
  - rx=1: false start; return to IDLE with armed=1 and no outputs.
  - rx=0: go to DATA, load counter CLKS_PER_BIT-1, bit index=0.
- DATA:
  - At each counter 0, shift rx into data bit [index] and reload CLKS_PER_BIT-1.
  - After index DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - At counter 0, sample rx.
  - perr = (XOR of data bits ^ rx) != (PARITY==1 ? 1 : 0). That is, odd parity requires the total count of ones to be odd, even parity requires it to be even.
- STOP:
  - At counter 0, sample rx. Any stop sample of 0 sets ferr.
  - With STOP_BITS=2, sample the second stop bit one full bit later.
  - After the final stop sample, the frame is complete. Return to IDLE the same cycle.
  - armed = final stop sample, so after a break (line low) the FSM waits for high before re-arming.
- Completion timing: the output register updates on the cycle after the final stop sample.
- Output register update on completion:
  - If data_valid=0, or data_valid && data_ready in the same cycle: load data, parity_err and frame_err; data_valid=1.
  - Else: keep the old word and flags, pulse overrun for 1 cycle, and drop the new frame.
- Acceptance: data_valid && data_ready with no simultaneous completion clears data_valid and the flags next cycle.
- Errored frames are still delivered; the flags qualify the word.
- Latency: a falling edge on uart_in is seen at rx after SYNC_STAGES cycles.
- Total frame time: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, within ±1 cycle of edge alignment.
- Back-to-back frames: a start bit immediately after the stop bit is detected, because armed=1 after a high stop sample.

Test Plan:
- 8N1, CLKS_PER_BIT=16, send 0x55 then 0xA3 with data_ready=1 -> two data_valid words 0x55 and 0xA3, no error flags, busy low between frames.
- PARITY=2, send 0x07 with parity bit 0 (correct bit is 1) -> data=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Line held low for 20 bit times (break) -> one word 0x00 with frame_err=1. No further start detected until uart_in returns high; then 0x3C is received cleanly.
- Low glitch of 3 cycles on an idle line -> busy pulses, returns to IDLE, no data_valid, no error flags.
- data_ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses exactly 1 cycle at 0x22 completion. Then raise data_ready -> 0x11 is accepted and data_valid drops.
- Assert reset for 1 cycle mid-DATA of a frame -> all outputs 0, busy=0, no word from that frame. A following clean frame 0x9E is received correctly.
- DATA_BITS=9, STOP_BITS=2, send 0x1A5 -> data=0x1A5. A second stop bit sampled low sets frame_err=1.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampling UART receiver with configurable frame format
// Mid-bit sampling, start-bit validation, parity/frame flags and a valid/ready output register.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 uart_clk,
  input  logic                 reset,
  input  logic                 uart_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr;
  logic                   ferr;
  logic                   done;

  assign rx = sync[SYNC_STAGES-1];

  // Synchroniser resets to the idle-high level so no false start follows reset.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], uart_in};
    end
  end

  always_ff @(posedge uart_clk) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            cnt   <= HALF_M1;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx) begin
            state <= IDLE;
            armed <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= DATA;
            cnt   <= FULL_M1;
            idx   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[idx] <= rx;
            cnt        <= FULL_M1;
            if (idx == LAST_IDX) begin
              stop_idx <= 1'b0;
              state    <= (PARITY != 0) ? PAR : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PAR: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            perr  <= (^shreg ^ rx) != ODD;
            cnt   <= FULL_M1;
            state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!rx) ferr <= 1'b1;
            if (stop_idx == LAST_STOP) begin
              // A low final stop (break) leaves armed clear until the line idles high.
              state <= IDLE;
              busy  <= 1'b0;
              armed <= rx;
              done  <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
              cnt      <= FULL_M1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge uart_clk) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!data_valid || data_ready) begin
          data       <= shreg;
          parity_err <= perr;
          frame_err  <= ferr;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg
// Three instances cover 8N1, 8E1 and 9N2 frame formats.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic l0 = 1'b1, l1 = 1'b1, l2 = 1'b1;
  logic r0 = 1'b1, r1 = 1'b1, r2 = 1'b1;
  logic [7:0] d0, d1;
  logic [8:0] d2;
  logic v0, v1, v2, p0, p1, p2, f0, f1, f2, o0, o1, o2, b0, b1, b2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut0 (
    .uart_clk(clk), .reset(reset), .uart_in(l0), .data(d0), .data_valid(v0),
    .data_ready(r0), .parity_err(p0), .frame_err(f0), .overrun(o0), .busy(b0));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut1 (
    .uart_clk(clk), .reset(reset), .uart_in(l1), .data(d1), .data_valid(v1),
    .data_ready(r1), .parity_err(p1), .frame_err(f1), .overrun(o1), .busy(b1));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .STOP_BITS(2)) dut2 (
    .uart_clk(clk), .reset(reset), .uart_in(l2), .data(d2), .data_valid(v2),
    .data_ready(r2), .parity_err(p2), .frame_err(f2), .overrun(o2), .busy(b2));

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
  } word_t;

  word_t q0[$], q1[$], q2[$];
  int ovr0 = 0;
  int checks = 0;
  int errors = 0;

  // Capture every handshake on the falling edge, before the transfer edge.
  always @(negedge clk) begin
    if (v0 && r0) q0.push_back(word_t'({1'b0, d0, p0, f0}));
    if (v1 && r1) q1.push_back(word_t'({1'b0, d1, p1, f1}));
    if (v2 && r2) q2.push_back(word_t'({d2, p2, f2}));
    if (o0) ovr0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0: l0 = v;
      1: l1 = v;
      default: l2 = v;
    endcase
  endtask

  task automatic send(input int which, input logic [8:0] d, input int nd, input bit has_par,
                      input logic pbit, input int nstop, input logic s2, input int limit);
    logic [15:0] fr;
    int len;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < nd; i++) fr[1+i] = d[i];
    len = 1 + nd;
    if (has_par) begin
      fr[len] = pbit;
      len++;
    end
    fr[len] = 1'b1;
    len++;
    if (nstop == 2) begin
      fr[len] = s2;
      len++;
    end
    if (limit < len) len = limit;
    for (int b = 0; b < len; b++) begin
      set_line(which, fr[b]);
      idle(CPB);
    end
    set_line(which, 1'b1);
  endtask

  initial begin
    idle(2);
    chk("reset_data0", {24'd0, d0}, 32'h0);
    chk("reset_flags0", {v0, p0, f0, o0, b0}, 5'b0);
    chk("reset_out2", {d2, v2, p2, f2, o2, b2}, 14'b0);
    reset = 1'b0;
    idle(4);

    // 8N1 back to back
    send(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    chk("busy_between", b0, 1'b0);
    send(0, 9'h0A3, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    idle(4);
    chk("t1_count", q0.size(), 2);
    chk("t1_w0", q0[0], {9'h055, 2'b00});
    chk("t1_w1", q0[1], {9'h0A3, 2'b00});
    q0.delete();

    // 3-cycle low glitch
    l0 = 1'b0;
    idle(3);
    l0 = 1'b1;
    idle(1);
    chk("glitch_busy_hi", b0, 1'b1);
    idle(20);
    chk("glitch_busy_lo", b0, 1'b0);
    chk("glitch_no_word", {v0, p0, f0}, 3'b0);
    chk("glitch_q", q0.size(), 0);

    // Break: 20 bit times low
    l0 = 1'b0;
    idle(20 * CPB);
    chk("break_count", q0.size(), 1);
    chk("break_word", q0[0], {9'h000, 2'b01});
    chk("break_busy", b0, 1'b0);
    l0 = 1'b1;
    idle(2 * CPB);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    idle(4);
    chk("after_break_count", q0.size(), 2);
    chk("after_break_word", q0[1], {9'h03C, 2'b00});
    q0.delete();

    // Overrun with consumer stalled
    r0 = 1'b0;
    send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    idle(4);
    chk("ovr_valid", v0, 1'b1);
    chk("ovr_data", {24'd0, d0}, 32'h11);
    chk("ovr_pulses", ovr0, 1);
    r0 = 1'b1;
    idle(2);
    chk("ovr_drain_valid", v0, 1'b0);
    chk("ovr_drain_count", q0.size(), 1);
    chk("ovr_drain_word", q0[0], {9'h011, 2'b00});
    q0.delete();

    // Reset in the middle of the data bits
    send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 4);
    chk("rst_busy_before", b0, 1'b1);
    reset = 1'b1;
    idle(1);
    chk("rst_outs0", {d0, v0, p0, f0, o0, b0}, 13'b0);
    reset = 1'b0;
    idle(3 * CPB);
    chk("rst_no_word", q0.size(), 0);
    send(0, 9'h09E, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    idle(4);
    chk("rst_next_count", q0.size(), 1);
    chk("rst_next_word", q0[0], {9'h09E, 2'b00});

    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    send(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, 99);
    send(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 99);
    idle(4);
    chk("par_count", q1.size(), 2);
    chk("par_bad", q1[0], {9'h007, 2'b10});
    chk("par_good", q1[1], {9'h007, 2'b00});

    // 9 data bits, 2 stop bits; second frame has a low second stop
    send(2, 9'h1A5, 9, 1'b0, 1'b0, 2, 1'b1, 99);
    send(2, 9'h1A5, 9, 1'b0, 1'b0, 2, 1'b0, 99);
    idle(4);
    chk("nine_count", q2.size(), 2);
    chk("nine_clean", q2[0], {9'h1A5, 2'b00});
    chk("nine_stop2_low", q2[1], {9'h1A5, 2'b01});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
